rv0_alu_f_seq: RTL and testbench

// - Issue sequencer for rv0_alu_f: accepts FP ops from decode, classifies them, issues to the FP ALU.
// - Schedules the single FP writeback port; stalls on writeback collision or busy iterative unit.
// - Handles pipeline flush: kills in-flight ops and aborts div/sqrt.
// - Sits between the FP issue stage and rv0_alu_f; drives FP register-file writeback timing.

---
 rtl/rv0_fpu_pkg.sv | 51 +++++
 rtl/rv0_alu_f_wb_rsv.sv | 57 +++++
 rtl/rv0_alu_f_seq.sv | 95 +++++++++
 tb/tb_rv0_alu_f_seq.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/rv0_fpu_pkg.sv
// FP op codes, issue classes and default class latencies shared by the FP sequencer.
package rv0_fpu_pkg;

  localparam int FOP_W_D    = 5;
  localparam int RD_W_D     = 5;
  localparam int LAT_MISC_D = 1;
  localparam int LAT_PIPE_D = 3;
  localparam int LAT_ITER_D = 24;

  typedef enum logic [FOP_W_D-1:0] {
    FOP_FADD   = 5'd0,
    FOP_FSUB   = 5'd1,
    FOP_FMUL   = 5'd2,
    FOP_FMADD  = 5'd3,
    FOP_FMSUB  = 5'd4,
    FOP_FNMSUB = 5'd5,
    FOP_FNMADD = 5'd6,
    FOP_FDIV   = 5'd7,
    FOP_FSQRT  = 5'd8,
    FOP_FSGNJ  = 5'd9,
    FOP_FSGNJN = 5'd10,
    FOP_FSGNJX = 5'd11,
    FOP_FMIN   = 5'd12,
    FOP_FMAX   = 5'd13,
    FOP_FEQ    = 5'd14,
    FOP_FLT    = 5'd15,
    FOP_FLE    = 5'd16,
    FOP_FCLASS = 5'd17,
    FOP_FMVXW  = 5'd18,
    FOP_FMVWX  = 5'd19
  } fop_e;

  typedef enum logic [1:0] {
    CLS_MISC = 2'd0,
    CLS_PIPE = 2'd1,
    CLS_ITER = 2'd2
  } fop_cls_e;

  // Anything not recognised as arithmetic or iterative falls back to MISC.
  function automatic fop_cls_e fop_class(input logic [FOP_W_D-1:0] op);
    fop_cls_e cls;
    case (op)
      FOP_FADD, FOP_FSUB, FOP_FMUL, FOP_FMADD,
      FOP_FMSUB, FOP_FNMSUB, FOP_FNMADD: cls = CLS_PIPE;
      FOP_FDIV, FOP_FSQRT:               cls = CLS_ITER;
      default:                           cls = CLS_MISC;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/rv0_alu_f_wb_rsv.sv
// Purpose: writeback reservation shift register; entry i holds the op writing back i cycles from now.
// Latency: entry 0 is the live writeback register; a write at offset L appears on head L cycles later.
// Backpressure: none; callers must consult slot_free before writing.
module rv0_alu_f_wb_rsv #(
  parameter int DEPTH = 24,
  parameter int RD_W  = 5,
  parameter int OFS_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [OFS_W-1:0] wr_ofs,
  input  logic [RD_W-1:0]  wr_rd,
  output logic [DEPTH:0]   slot_free,
  output logic             head_vld,
  output logic [RD_W-1:0]  head_rd,
  output logic             any_vld
);

  logic [DEPTH-1:0] vld;
  logic [RD_W-1:0]  rd [DEPTH];

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      vld <= '0;
      for (int i = 0; i < DEPTH; i++) rd[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        vld[i] <= vld[i+1];
        rd[i]  <= rd[i+1];
      end
      vld[DEPTH-1] <= 1'b0;
      rd[DEPTH-1]  <= '0;
      // Offset is measured from the current cycle, so it lands one entry lower after the shift.
      if (wr_en) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (wr_ofs == OFS_W'(i + 1)) begin
            vld[i] <= 1'b1;
            rd[i]  <= wr_rd;
          end
        end
      end
    end
  end

  always_comb begin
    slot_free        = '0;
    slot_free[DEPTH] = 1'b1;
    for (int i = 0; i < DEPTH; i++) slot_free[i] = !vld[i];
  end

  assign head_vld = vld[0];
  assign head_rd  = rd[0];
  assign any_vld  = |vld;

endmodule

// File: rtl/rv0_alu_f_seq.sv
// Purpose: FP issue sequencer; classifies ops, schedules the single writeback port, tracks div/sqrt.
// Latency: req to alu issue is combinational; writeback lands exactly LAT_<class> cycles after accept.
// Backpressure: req_rdy drops on writeback slot collision, busy iterative unit, flush or reset.
module rv0_alu_f_seq
  import rv0_fpu_pkg::*;
#(
  parameter int FOP_W    = FOP_W_D,
  parameter int RD_W     = RD_W_D,
  parameter int LAT_MISC = LAT_MISC_D,
  parameter int LAT_PIPE = LAT_PIPE_D,
  parameter int LAT_ITER = LAT_ITER_D
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             req_vld,
  output logic             req_rdy,
  input  logic [FOP_W-1:0] req_op,
  input  logic [2:0]       req_rm,
  input  logic [RD_W-1:0]  req_rd,
  output logic             alu_vld,
  output logic [FOP_W-1:0] alu_op,
  output logic [2:0]       alu_rm,
  output logic             alu_iter_go,
  output logic             alu_kill,
  output logic             wb_vld,
  output logic [RD_W-1:0]  wb_rd,
  output logic             iter_busy,
  output logic             busy
);

  localparam int OFS_W = $clog2(LAT_ITER + 1);
  localparam int CNT_W = $clog2(LAT_ITER);

  fop_cls_e         cls;
  logic [OFS_W-1:0] lat;
  logic [LAT_ITER:0] slot_free;
  logic             head_vld;
  logic [RD_W-1:0]  head_rd;
  logic             any_vld;
  logic [CNT_W-1:0] iter_cnt;

  assign cls = fop_class(req_op);

  always_comb begin
    lat = OFS_W'(LAT_MISC);
    case (cls)
      CLS_PIPE: lat = OFS_W'(LAT_PIPE);
      CLS_ITER: lat = OFS_W'(LAT_ITER);
      default:  lat = OFS_W'(LAT_MISC);
    endcase
  end

  assign iter_busy   = (iter_cnt != '0);
  assign req_rdy     = !rst && !flush && slot_free[lat] && !(cls == CLS_ITER && iter_busy);
  assign alu_vld     = req_vld && req_rdy;
  assign alu_op      = req_op;
  assign alu_rm      = req_rm;
  assign alu_iter_go = alu_vld && (cls == CLS_ITER);
  assign alu_kill    = flush;

  // Counts the remaining busy cycles after an ITER issue; next ITER may go once it reaches zero.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      iter_cnt <= '0;
    end else if (alu_iter_go) begin
      iter_cnt <= CNT_W'(LAT_ITER - 1);
    end else if (iter_busy) begin
      iter_cnt <= iter_cnt - 1'b1;
    end
  end

  rv0_alu_f_wb_rsv #(
    .DEPTH (LAT_ITER),
    .RD_W  (RD_W),
    .OFS_W (OFS_W)
  ) u_wb_rsv (
    .clk       (clk),
    .rst       (rst),
    .clr       (flush),
    .wr_en     (alu_vld),
    .wr_ofs    (lat),
    .wr_rd     (req_rd),
    .slot_free (slot_free),
    .head_vld  (head_vld),
    .head_rd   (head_rd),
    .any_vld   (any_vld)
  );

  // A flushed cycle must not retire anything even though the head entry is still occupied.
  assign wb_vld = head_vld && !flush && !rst;
  assign wb_rd  = head_rd;
  assign busy   = iter_busy || any_vld || wb_vld;

endmodule

// File: tb/tb_rv0_alu_f_seq.sv
// Directed bench for the FP issue sequencer: latency, collisions, iterative unit, flush and reset.
module tb_rv0_alu_f_seq;
  import rv0_fpu_pkg::*;

  logic       clk = 1'b0;
  logic       rst, flush, req_vld, req_rdy;
  logic [4:0] req_op, req_rd, alu_op, wb_rd;
  logic [2:0] req_rm, alu_rm;
  logic       alu_vld, alu_iter_go, alu_kill, wb_vld, iter_busy, busy;

  int ntests = 0;
  int nfail  = 0;

  always #5 clk = ~clk;

  rv0_alu_f_seq dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .req_vld     (req_vld),
    .req_rdy     (req_rdy),
    .req_op      (req_op),
    .req_rm      (req_rm),
    .req_rd      (req_rd),
    .alu_vld     (alu_vld),
    .alu_op      (alu_op),
    .alu_rm      (alu_rm),
    .alu_iter_go (alu_iter_go),
    .alu_kill    (alu_kill),
    .wb_vld      (wb_vld),
    .wb_rd       (wb_rd),
    .iter_busy   (iter_busy),
    .busy        (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance into the next cycle; inputs change 1 time unit after the edge, checks follow at +3.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] op, input logic [4:0] rd);
    req_vld = v;
    req_op  = op;
    req_rd  = rd;
    #2;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; req_vld = 1'b0; req_op = '0; req_rm = 3'd2; req_rd = '0;

    // Reset with a pending request
    tick(); drive(1'b1, FOP_FADD, 5'd3);
    tick(); #2;
    chk("rst_rdy", {31'd0, req_rdy}, 32'd0);
    chk("rst_wb_vld", {31'd0, wb_vld}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_iter_busy", {31'd0, iter_busy}, 32'd0);
    chk("rst_wb_rd", {27'd0, wb_rd}, 32'd0);

    // FADD rd=3 at c0, wb in c3; FSGNJ rd=7 at c2 collides with it
    tick(); rst = 1'b0; drive(1'b1, FOP_FADD, 5'd3);
    chk("fadd_rdy", {31'd0, req_rdy}, 32'd1);
    chk("fadd_alu_vld", {31'd0, alu_vld}, 32'd1);
    chk("fadd_alu_op", {27'd0, alu_op}, 32'd0);
    chk("fadd_alu_rm", {29'd0, alu_rm}, 32'd2);
    chk("fadd_iter_go", {31'd0, alu_iter_go}, 32'd0);
    tick(); drive(1'b0, FOP_FADD, 5'd0);
    chk("fadd_wb_c1", {31'd0, wb_vld}, 32'd0);
    chk("fadd_busy_c1", {31'd0, busy}, 32'd1);
    tick(); drive(1'b1, FOP_FSGNJ, 5'd7);
    chk("coll_rdy_c2", {31'd0, req_rdy}, 32'd0);
    chk("coll_alu_vld_c2", {31'd0, alu_vld}, 32'd0);
    chk("fadd_wb_c2", {31'd0, wb_vld}, 32'd0);
    tick(); #2;
    chk("coll_rdy_c3", {31'd0, req_rdy}, 32'd1);
    chk("fadd_wb_c3", {31'd0, wb_vld}, 32'd1);
    chk("fadd_wb_rd_c3", {27'd0, wb_rd}, 32'd3);
    tick(); drive(1'b0, FOP_FADD, 5'd0);
    chk("sgnj_wb_c4", {31'd0, wb_vld}, 32'd1);
    chk("sgnj_wb_rd_c4", {27'd0, wb_rd}, 32'd7);
    tick(); #2;
    chk("idle_wb_c5", {31'd0, wb_vld}, 32'd0);
    chk("idle_busy_c5", {31'd0, busy}, 32'd0);

    // Undefined op code falls into MISC (one-cycle latency)
    tick(); drive(1'b1, 5'h1F, 5'd12);
    chk("undef_rdy", {31'd0, req_rdy}, 32'd1);
    tick(); drive(1'b0, FOP_FADD, 5'd0);
    chk("undef_wb", {31'd0, wb_vld}, 32'd1);
    chk("undef_wb_rd", {27'd0, wb_rd}, 32'd12);

    // FDIV rd=4 at c0; FADD rd=9 at c1 slips in; second FDIV rd=5 held until c24
    tick(); drive(1'b1, FOP_FDIV, 5'd4);
    chk("fdiv_rdy", {31'd0, req_rdy}, 32'd1);
    chk("fdiv_iter_go", {31'd0, alu_iter_go}, 32'd1);
    chk("fdiv_ib_c0", {31'd0, iter_busy}, 32'd0);
    tick(); drive(1'b1, FOP_FADD, 5'd9);
    chk("fdiv_ib_c1", {31'd0, iter_busy}, 32'd1);
    chk("fadd_under_div_rdy", {31'd0, req_rdy}, 32'd1);
    for (int c = 2; c < 24; c++) begin
      tick(); drive(1'b1, FOP_FDIV, 5'd5);
      chk("fdiv2_held", {31'd0, req_rdy}, 32'd0);
      chk("fdiv_ib_held", {31'd0, iter_busy}, 32'd1);
      chk("fdiv2_no_go", {31'd0, alu_iter_go}, 32'd0);
      if (c == 4) begin
        chk("fadd9_wb", {31'd0, wb_vld}, 32'd1);
        chk("fadd9_wb_rd", {27'd0, wb_rd}, 32'd9);
      end else begin
        chk("div_wb_quiet", {31'd0, wb_vld}, 32'd0);
      end
    end
    tick(); #2;
    chk("fdiv_ib_c24", {31'd0, iter_busy}, 32'd0);
    chk("fdiv2_rdy_c24", {31'd0, req_rdy}, 32'd1);
    chk("fdiv2_go_c24", {31'd0, alu_iter_go}, 32'd1);
    chk("fdiv_wb_c24", {31'd0, wb_vld}, 32'd1);
    chk("fdiv_wb_rd_c24", {27'd0, wb_rd}, 32'd4);

    // FADD rd=10 at c25 (due c28), flush at c27 kills it and the second FDIV
    tick(); drive(1'b1, FOP_FADD, 5'd10);
    chk("pre_flush_rdy", {31'd0, req_rdy}, 32'd1);
    tick(); drive(1'b0, FOP_FADD, 5'd0);
    tick(); flush = 1'b1; drive(1'b1, FOP_FADD, 5'd11);
    chk("flush_kill", {31'd0, alu_kill}, 32'd1);
    chk("flush_rdy", {31'd0, req_rdy}, 32'd0);
    chk("flush_alu_vld", {31'd0, alu_vld}, 32'd0);
    chk("flush_wb", {31'd0, wb_vld}, 32'd0);
    tick(); flush = 1'b0; drive(1'b0, FOP_FDIV, 5'd0);
    chk("post_flush_kill", {31'd0, alu_kill}, 32'd0);
    chk("post_flush_wb", {31'd0, wb_vld}, 32'd0);
    chk("post_flush_ib", {31'd0, iter_busy}, 32'd0);
    chk("post_flush_busy", {31'd0, busy}, 32'd0);
    chk("post_flush_rdy", {31'd0, req_rdy}, 32'd1);
    tick(); #2;
    chk("post_flush_wb2", {31'd0, wb_vld}, 32'd0);

    // Back-to-back FADDs rd=1..6, writebacks three cycles later in order
    for (int i = 0; i < 9; i++) begin
      tick();
      if (i < 6) drive(1'b1, FOP_FADD, 5'(i + 1));
      else       drive(1'b0, FOP_FADD, 5'd0);
      if (i < 6) chk("b2b_rdy", {31'd0, req_rdy}, 32'd1);
      if (i >= 3) begin
        chk("b2b_wb", {31'd0, wb_vld}, 32'd1);
        chk("b2b_wb_rd", {27'd0, wb_rd}, 32'(i - 2));
      end else begin
        chk("b2b_wb_early", {31'd0, wb_vld}, 32'd0);
      end
    end
    tick(); #2;
    chk("b2b_wb_done", {31'd0, wb_vld}, 32'd0);

    // FSQRT is ITER class; reset mid-flight drops it and a pending FADD
    tick(); drive(1'b1, FOP_FSQRT, 5'd13);
    chk("fsqrt_go", {31'd0, alu_iter_go}, 32'd1);
    tick(); drive(1'b1, FOP_FMUL, 5'd14);
    chk("fmul_rdy", {31'd0, req_rdy}, 32'd1);
    chk("fsqrt_ib", {31'd0, iter_busy}, 32'd1);
    tick(); rst = 1'b1; drive(1'b1, FOP_FADD, 5'd15);
    chk("rst_mid_rdy", {31'd0, req_rdy}, 32'd0);
    tick(); rst = 1'b0; drive(1'b0, FOP_FADD, 5'd0);
    chk("rst_mid_ib", {31'd0, iter_busy}, 32'd0);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    tick(); #2;
    chk("rst_mid_wb", {31'd0, wb_vld}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
